// File: rtl/prog_loader_if.sv
// Stream, memory write port and CPU control bundle between the boot loader and its surroundings.
// master: the loader; slave: stream source, program memory and CPU core.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              halt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  modport master (
    input  in_valid, in_data, halt,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );

  modport slave (
    output in_valid, in_data, halt,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: length-prefixed byte stream -> CPU program memory, then releases the CPU.
// Optional trailing checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           rst,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERROR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = ST_CSUM;
`else
  localparam state_t POST_DATA = ST_RUN;
`endif

  state_t            state;
  state_t            state_next;
  logic              in_ready;
  logic              ready_next;
  logic              mem_we;
  logic              we_next;
  logic              cpu_rst;
  logic              cpu_rst_next;
  logic              done;
  logic              done_next;
  logic              err;
  logic              err_next;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        count;
  logic              xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
  logic [7:0]        csum_total;
  assign csum_total = sum + bus.in_data;
`endif

  assign xfer = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LEN;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= ready_next;
      mem_we   <= we_next;
      cpu_rst  <= cpu_rst_next;
      done     <= done_next;
      err      <= err_next;
    end
  end

  // done/cpu_rst follow the state one edge late so the last write lands before the CPU fetches.
  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    case (state)
      ST_LEN: begin
        if (xfer) state_next = (bus.in_data == 8'd0) ? POST_DATA : ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          we_next = 1'b1;
          if (count == 8'd1) state_next = POST_DATA;
        end
      end
      ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) state_next = (csum_total == 8'd0) ? ST_RUN : ST_ERROR;
`endif
      end
      ST_RUN: begin
        if (bus.halt) state_next = ST_LEN;
      end
      ST_ERROR: begin
        state_next = ST_ERROR;
      end
      default: state_next = ST_LEN;
    endcase
    ready_next   = (state_next == ST_LEN) || (state_next == ST_DATA) ||
                   (state_next == ST_CSUM);
    done_next    = (state == ST_RUN) && !bus.halt;
    cpu_rst_next = !done_next;
`ifdef LOADER_CHECKSUM_EN
    err_next     = (state_next == ST_ERROR);
`else
    err_next     = 1'b0;
`endif
  end

  // Address/count/checksum datapath and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= BASE_ADDR;
      count     <= 8'd0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      if (state == ST_LEN) begin
`ifdef LOADER_CHECKSUM_EN
        sum <= 8'd0;
`endif
        if (xfer) begin
          count <= bus.in_data;
          addr  <= BASE_ADDR;
        end
      end
      if (state == ST_DATA && xfer) begin
        mem_addr  <= addr;
        mem_wdata <= bus.in_data;
        addr      <= addr + ADDR_W'(1);
        count     <= count - 8'd1;
`ifdef LOADER_CHECKSUM_EN
        sum       <= csum_total;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_rst   = cpu_rst;
  assign bus.done      = done;
  assign bus.err       = err;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the 8-bit CPU core.
- Receives a byte stream over a valid/ready handshake and writes it into the CPU's program/data memory through a dedicated write port.
- Holds the CPU in reset while loading, then releases it.
- Re-arms for a new image when the CPU raises halt.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- BASE_ADDR, 0, first memory address written for each image.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- halt  input  1  CPU halt flag, level-sensitive.
- mem_we  output  1  memory write strobe, one cycle per byte.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- cpu_rst  output  1  reset to CPU core, active-high.
- done  output  1  image loaded, CPU running.
- err  output  1  load failed, sticky until rst.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge. All outputs are registered.
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, err=0. State goes to LEN.
- Reset mid-load discards the partial image. Bytes already written stay in memory.
- Transfer rule: a byte transfers on an edge where in_valid && in_ready. in_data is ignored otherwise. in_valid is never required to hold.
- State LEN: in_ready=1. The accepted byte is N, the image length.
  - N=0: go to CSUM if enabled, else RUN. No writes.
  - Else: load count=N, addr=BASE_ADDR, go to DATA.
- State DATA: in_ready=1. On each transfer at edge k:
  - mem_we=1, mem_addr=addr, mem_wdata=in_data become visible after edge k. Memory captures at edge k+1.
  - addr increments with wrap (BASE_ADDR=255 then next is 0); count decrements.
  - mem_we returns to 0 after edge k+1 unless another transfer occurs at edge k+1. Back-to-back bytes give continuous mem_we.
  - When the transfer with count=1 occurs, go to CSUM (if enabled), else RUN.
- State RUN: in_ready=0, done=1.
  - cpu_rst falls on the edge after the final write pulse (edge k+1 for the last byte at edge k), so the CPU's first fetch sees the complete image.
  - If halt=1 in RUN: on the next edge cpu_rst=1, done=0, state goes to LEN.
  - halt while not in RUN is ignored.
- State ERROR: in_ready=0, err=1, cpu_rst=1, done=0. Left only by rst.
- Invariants:
  - cpu_rst and done are never both 1.
  - mem_we is never 1 while cpu_rst=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the N data bytes (or directly after N=0), state CSUM accepts one byte C with in_ready=1. It is not written to memory.
  - If (sum of the N data bytes + C) mod 256 == 0, go to RUN.
  - Else go to ERROR on the same edge (err=1 after that edge).
  - The running sum is 8-bit and is cleared in LEN.
- Not defined:
  - No CSUM state; DATA goes straight to RUN.
  - ERROR is unreachable and err stays 0.

Test Plan:
- Reset then stream 03,A1,B2,C3 with in_valid held high (no checksum) -> three consecutive mem_we cycles at addr 00,01,02 with data A1,B2,C3; cpu_rst=0 and done=1 one cycle after the last mem_we; in_ready=0 from then.
- Same stream with gaps (in_valid toggled 1,0,0,1...) plus in_valid pulses while in RUN -> writes occur only on handshake edges; no writes or state change from RUN-phase bytes.
- LOADER_CHECKSUM_EN, stream 02,10,20,D0 -> writes 10@00, 20@01; RUN reached. Stream 02,10,20,D1 -> err=1, cpu_rst stays 1, in_ready=0, no further writes.
- BASE_ADDR=FE, stream 03,11,22,33 -> writes at FE,FF,00 (wrap).
- Load 01,55; in RUN raise halt=1 for one cycle -> next edge cpu_rst=1, done=0, in_ready=1. Stream 01,66 -> 66 written at 00; CPU released again.
- Assert rst after the 2nd data byte of 04,... -> all outputs return to reset values next edge. A fresh 01,77 loads correctly. Also check N=00 -> RUN with no mem_we.
